// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter for the common data bus.
// Functional units raise req_i when they hold a finished result. One FU is
// granted per cycle (combinational grant_o), and the winner's tag (index+1)
// and result are broadcast on the registered cdb_* outputs on the next edge.
// Tag 0 is reserved for "no producer" and is never broadcast as valid.
// The design requires 2**Q_WIDTH > N_FU so that every FU has a nonzero tag.
module cdb_arbiter #(
  parameter int N_FU       = 9,
  parameter int Q_WIDTH    = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N_FU-1:0]            req_i,
  input  logic [N_FU*DATA_WIDTH-1:0] req_data_i,
  input  logic                       cdb_hold_i,
  output logic [N_FU-1:0]            grant_o,
  output logic                       cdb_valid_o,
  output logic [Q_WIDTH-1:0]         cdb_tag_o,
  output logic [DATA_WIDTH-1:0]      cdb_data_o
);

  localparam int PTR_W = (N_FU > 1) ? $clog2(N_FU) : 1;
  localparam int CAND_W = PTR_W + 1;
  localparam logic [CAND_W-1:0] N_FU_C = CAND_W'(N_FU);
  localparam logic [PTR_W-1:0] LAST_FU = PTR_W'(N_FU - 1);

  // Round-robin pointer: the FU searched first in the current cycle.
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic                  valid_q, valid_d;
  logic [Q_WIDTH-1:0]    tag_q, tag_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic                  win_found;
  logic [PTR_W-1:0]      win_idx;
  logic                  win_valid;
  logic [DATA_WIDTH-1:0] win_data;

  // Search ptr, ptr+1, ... wrapping modulo N_FU; the first requester wins.
  always_comb begin
    logic [CAND_W-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_FU; k++) begin
      cand = {1'b0, ptr_q} + CAND_W'(k);
      if (cand >= N_FU_C) begin
        cand = cand - N_FU_C;
      end
      if (!win_found && req_i[cand[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // Hold and reset both suppress the grant in the same cycle they are seen.
  assign win_valid = win_found && !cdb_hold_i && !rst_i;

  // One-hot acknowledge to the winning FU, or all zero.
  always_comb begin
    grant_o = '0;
    if (win_valid) begin
      grant_o[win_idx] = 1'b1;
    end
  end

  // AND-OR select of the granted FU's result slice.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < N_FU; i++) begin
      if (grant_o[i]) begin
        win_data = win_data | req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state for the broadcast registers and the round-robin pointer.
  always_comb begin
    valid_d = 1'b0;
    tag_d   = '0;
    data_d  = '0;
    ptr_d   = ptr_q;
    if (win_valid) begin
      valid_d = 1'b1;
      tag_d   = Q_WIDTH'(win_idx) + Q_WIDTH'(1);
      data_d  = win_data;
      ptr_d   = (win_idx == LAST_FU) ? '0 : win_idx + PTR_W'(1);
    end
  end

  // Registered CDB and pointer; synchronous reset takes priority.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
    end
  end

  assign cdb_valid_o = valid_q;
  assign cdb_tag_o   = tag_q;
  assign cdb_data_o  = data_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed tests for the round-robin CDB arbiter.
module tb_cdb_arbiter;

  localparam int N_FU = 9;
  localparam int QW   = 4;
  localparam int DW   = 32;

  logic                 clk;
  logic                 rst;
  logic [N_FU-1:0]      req;
  logic [N_FU*DW-1:0]   req_data;
  logic                 hold;
  logic [N_FU-1:0]      grant;
  logic                 cdb_valid;
  logic [QW-1:0]        cdb_tag;
  logic [DW-1:0]        cdb_data;

  int checks = 0;
  int errors = 0;

  cdb_arbiter #(.N_FU(N_FU), .Q_WIDTH(QW), .DATA_WIDTH(DW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .req_data_i (req_data),
    .cdb_hold_i (hold),
    .grant_o    (grant),
    .cdb_valid_o(cdb_valid),
    .cdb_tag_o  (cdb_tag),
    .cdb_data_o (cdb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] fu_data(input int i);
    return 32'hC0DE_0000 | DW'(i * 16 + 5);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (grant !== 9'h000) begin $display("FAIL reset_grant cyc%0d got %h want 000", c, grant); errors++; end
      checks++;
      if (cdb_valid !== 1'b0 || cdb_tag !== 4'd0 || cdb_data !== 32'd0) begin
        $display("FAIL reset_cdb cyc%0d got v=%b t=%0d d=%h want 0/0/0", c, cdb_valid, cdb_tag, cdb_data); errors++;
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (grant !== 9'h001) begin $display("FAIL reset_first_grant got %h want 001", grant); errors++; end
    tick();
    checks++;
    if (cdb_valid !== 1'b1 || cdb_tag !== 4'd1 || cdb_data !== fu_data(0)) begin
      $display("FAIL reset_first_bcast got v=%b t=%0d d=%h want 1/1/%h", cdb_valid, cdb_tag, cdb_data, fu_data(0)); errors++;
    end
    req = '0;
    tick();
  endtask

  // Pointer is 1 on entry.
  task automatic test_single();
    req_data[3*DW +: DW] = 32'hDEAD_BEEF;
    req = 9'h008;
    #1;
    checks++;
    if (grant !== 9'h008) begin $display("FAIL single_grant got %h want 008", grant); errors++; end
    tick();
    checks++;
    if (cdb_valid !== 1'b1 || cdb_tag !== 4'd4 || cdb_data !== 32'hDEAD_BEEF) begin
      $display("FAIL single_bcast got v=%b t=%0d d=%h want 1/4/deadbeef", cdb_valid, cdb_tag, cdb_data); errors++;
    end
    req = '0;
    req_data[3*DW +: DW] = fu_data(3);
    tick();
    checks++;
    if (cdb_valid !== 1'b0 || cdb_tag !== 4'd0 || cdb_data !== 32'd0) begin
      $display("FAIL single_drop got v=%b t=%0d d=%h want 0/0/0", cdb_valid, cdb_tag, cdb_data); errors++;
    end
  endtask

  task automatic test_round_robin();
    logic [N_FU-1:0] exp_g;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 9'h1FF;
    for (int k = 0; k < 10; k++) begin
      #1;
      exp_g = 9'h001 << (k % N_FU);
      checks++;
      if (grant !== exp_g) begin $display("FAIL rr_grant k%0d got %h want %h", k, grant, exp_g); errors++; end
      tick();
      checks++;
      if (cdb_valid !== 1'b1 || cdb_tag !== QW'(k % N_FU + 1) || cdb_data !== fu_data(k % N_FU)) begin
        $display("FAIL rr_bcast k%0d got v=%b t=%0d d=%h want 1/%0d/%h", k, cdb_valid, cdb_tag, cdb_data,
                 k % N_FU + 1, fu_data(k % N_FU)); errors++;
      end
    end
    req = '0;
    tick();
  endtask

  // Pointer is 1 on entry.
  task automatic test_wrap();
    req = 9'h080;
    tick();
    checks++;
    if (cdb_tag !== 4'd8 || cdb_valid !== 1'b1) begin $display("FAIL wrap_fu7 got t=%0d v=%b want 8/1", cdb_tag, cdb_valid); errors++; end
    req = 9'h101;
    #1;
    checks++;
    if (grant !== 9'h100) begin $display("FAIL wrap_grant8 got %h want 100", grant); errors++; end
    tick();
    checks++;
    if (cdb_tag !== 4'd9 || cdb_data !== fu_data(8)) begin $display("FAIL wrap_tag9 got t=%0d d=%h want 9/%h", cdb_tag, cdb_data, fu_data(8)); errors++; end
    req = 9'h001;
    #1;
    checks++;
    if (grant !== 9'h001) begin $display("FAIL wrap_grant0 got %h want 001", grant); errors++; end
    tick();
    checks++;
    if (cdb_tag !== 4'd1 || cdb_valid !== 1'b1) begin $display("FAIL wrap_tag1 got t=%0d v=%b want 1/1", cdb_tag, cdb_valid); errors++; end
    req = '0;
    tick();
  endtask

  // Pointer is 1 on entry.
  task automatic test_hold();
    hold = 1'b1;
    req  = 9'h004;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (grant !== 9'h000) begin $display("FAIL hold_grant cyc%0d got %h want 000", c, grant); errors++; end
      tick();
      checks++;
      if (cdb_valid !== 1'b0 || cdb_tag !== 4'd0) begin $display("FAIL hold_valid cyc%0d got v=%b t=%0d want 0/0", c, cdb_valid, cdb_tag); errors++; end
    end
    hold = 1'b0;
    #1;
    checks++;
    if (grant !== 9'h004) begin $display("FAIL hold_release_grant got %h want 004", grant); errors++; end
    tick();
    checks++;
    if (cdb_valid !== 1'b1 || cdb_tag !== 4'd3) begin $display("FAIL hold_release_tag got v=%b t=%0d want 1/3", cdb_valid, cdb_tag); errors++; end
    // Pointer is now 3; a hold with every FU requesting must not move it.
    hold = 1'b1;
    req  = 9'h1FF;
    tick();
    tick();
    hold = 1'b0;
    #1;
    checks++;
    if (grant !== 9'h008) begin $display("FAIL hold_ptr_kept got %h want 008", grant); errors++; end
    tick();
    checks++;
    if (cdb_tag !== 4'd4) begin $display("FAIL hold_ptr_tag got t=%0d want 4", cdb_tag); errors++; end
    req = '0;
    tick();
  endtask

  // Pointer is 4 on entry, so req 006 selects FU1 first.
  task automatic test_reset_mid();
    req = 9'h006;
    #1;
    checks++;
    if (grant !== 9'h002) begin $display("FAIL rmid_pre_grant got %h want 002", grant); errors++; end
    rst = 1'b1;
    #1;
    checks++;
    if (grant !== 9'h000) begin $display("FAIL rmid_grant_forced got %h want 000", grant); errors++; end
    tick();
    checks++;
    if (cdb_valid !== 1'b0 || cdb_tag !== 4'd0) begin $display("FAIL rmid_cdb got v=%b t=%0d want 0/0", cdb_valid, cdb_tag); errors++; end
    rst = 1'b0;
    #1;
    checks++;
    if (grant !== 9'h002) begin $display("FAIL rmid_fu1_grant got %h want 002", grant); errors++; end
    tick();
    checks++;
    if (cdb_valid !== 1'b1 || cdb_tag !== 4'd2) begin $display("FAIL rmid_tag2 got v=%b t=%0d want 1/2", cdb_valid, cdb_tag); errors++; end
    req = 9'h004;
    tick();
    checks++;
    if (cdb_valid !== 1'b1 || cdb_tag !== 4'd3) begin $display("FAIL rmid_tag3 got v=%b t=%0d want 1/3", cdb_valid, cdb_tag); errors++; end
    // Pointer is now 3; a reset must bring it back to 0.
    req = 9'h1FF;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (grant !== 9'h001) begin $display("FAIL rmid_ptr_zero got %h want 001", grant); errors++; end
    tick();
    checks++;
    if (cdb_tag !== 4'd1) begin $display("FAIL rmid_ptr_tag got t=%0d want 1", cdb_tag); errors++; end
    req = '0;
    tick();
  endtask

  initial begin
    rst  = 1'b1;
    hold = 1'b0;
    req  = 9'h1FF;
    for (int i = 0; i < N_FU; i++) req_data[i*DW +: DW] = fu_data(i);
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_hold();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common-data-bus arbiter for the Tomasulo RV32 core. Functional units (FUs) finish execution and request the single result bus. The arbiter grants one FU per cycle using round-robin priority. It then broadcasts the winner's tag and result on a registered CDB. Reservation stations compare the broadcast tag against their Qj/Qk and take Vj/Vk from it, and the register result status (RRS) clears on the same broadcast.

## Interface
- N_FU, 9: number of requesting FUs. FU i owns tag i+1; tag 0 means "no producer".
- Q_WIDTH, 4: tag width. Must satisfy 2^Q_WIDTH > N_FU.
- DATA_WIDTH, 32: result width.

- clk  input  1  core clock. All state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N_FU  bit i set: FU i holds a finished result.
- req_data  input  N_FU*DATA_WIDTH  flattened results. FU i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- cdb_hold  input  1  stall from the controller (e.g. during flush). Suppresses granting.
- grant  output  N_FU  one-hot or zero. Combinational acknowledge to the winning FU.
- cdb_valid  output  1  registered. Broadcast valid this cycle.
- cdb_tag  output  Q_WIDTH  registered. Tag of the broadcast result.
- cdb_data  output  DATA_WIDTH  registered. Broadcast result.

## Operation
- Round-robin pointer `ptr`:
  - Range 0..N_FU-1, reset 0.
  - Search order is ptr, ptr+1, …, N_FU-1, 0, …, ptr-1.
  - The first FU with req set wins.
- grant is combinational:
  - grant = one-hot(winner) when any req is set, cdb_hold=0 and rst=0.
  - Otherwise grant = 0.
- On an edge with a winner w:
  - cdb_valid←1, cdb_tag←w+1, cdb_data←req_data slice w.
  - ptr←(w+1) mod N_FU. The wrap from N_FU-1 goes to 0.
- On an edge with no winner (no req, or cdb_hold=1):
  - cdb_valid←0. cdb_tag and cdb_data are set to 0.
  - ptr is unchanged.
- FU protocol:
  - The FU keeps req and its data stable until it samples grant=1.
  - It deasserts req in the following cycle.
  - If req is still high after a grant, that is a new request and is arbitrated normally. The arbiter does not filter it.
- Fairness: a continuously requesting FU is granted within N_FU cycles of cdb_hold=0 cycles.
- Broadcast properties:
  - Tag 0 is never broadcast with cdb_valid=1.
  - At most one grant bit is set per cycle.
- Reset: synchronous, wins over everything. At the edge it sets cdb_valid=0, cdb_tag=0, cdb_data=0, ptr=0.
- Reset mid-request: grant is forced to 0 while rst=1. A pending req is not lost and is arbitrated after rst falls. Re-issue is the FU's responsibility.

## Timing
- Grant latency: grant in the same cycle req is seen (0 cycles).
- Broadcast latency: the CDB is valid on the edge after the grant (1 cycle).
- Throughput: one broadcast per cycle when requests are continuous.
- Simultaneous requests: only one winner per cycle. Losers hold req and are served in pointer order on later cycles.
- cdb_hold:
  - Takes effect in the same cycle: grant=0 in that cycle, and cdb_valid=0 after the next edge.
  - Releasing hold resumes from the unchanged ptr.
- The registered outputs feed the RS and RRS compare logic directly. No combinational path from req to cdb_* is permitted.

## Test plan
- Reset: hold rst=1 for 2 cycles with req=9'h1FF -> grant=0, cdb_valid=0, cdb_tag=0, cdb_data=0. The first cycle after reset grants FU0 (grant=9'h001), and the next edge shows cdb_tag=1.
- Single request: req[3]=1, data 32'hDEAD_BEEF -> grant=9'h008 in that cycle; next edge cdb_valid=1, cdb_tag=4, cdb_data=32'hDEAD_BEEF. Drop req -> cdb_valid=0 on the following edge.
- Round robin: req=9'h1FF held for 10 cycles, ptr starting at 0 -> broadcast tags 1,2,…,9,1 in consecutive cycles, each with cdb_valid=1.
- Wrap-around: ptr=8 (after granting FU7), req=9'h101 -> FU8 granted first (tag 9), then FU0 (tag 1).
- Hold: req[2]=1 with cdb_hold=1 for 3 cycles -> grant=0 and cdb_valid=0 throughout. Release hold -> grant=9'h004 that cycle and tag 3 on the next edge. ptr is unchanged during the hold.
- Reset mid-stream: req=9'h006 with rst pulsed on the cycle FU1 is granted -> cdb_valid=0 after the edge and ptr=0. After rst falls, FU1 is granted first (tag 2), then FU2 (tag 3).
